// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : Byte/half/word load-store initiator for a word-organised data
//            memory; sub-word stores use read-modify-write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int MEM_WORDS = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_dmem,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_w,
    input  logic [31:0] mem_data_r
);

    localparam logic [29:0] c_mem_words = 30'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic        w_err;
    logic        w_is_sw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // rst is folded in so the unit never advertises readiness while held in reset
    assign req_ready = rst && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_is_sw   = req_store && (req_funct3 == 3'b010);

    assign w_err = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                || ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00))
                || (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111)
                || (req_store && req_funct3[2])
                || (req_addr[31:2] >= c_mem_words);

    always_comb begin
        w_byte   = mem_data_r[{r_addr, 3'b000} +: 8];
        w_half   = r_addr[1] ? mem_data_r[31:16] : mem_data_r[15:0];
        w_load   = mem_data_r;
        w_merged = mem_data_r;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = mem_data_r;
        endcase
        // Only the addressed lane changes; the rest of the fetched word is written back as-is
        if (r_funct3[1:0] == 2'b00)
            w_merged[{r_addr, 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_store    <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 2'b00;
            r_wdata    <= 32'h0;
            mem_dmem   <= 1'b1;
            mem_addr   <= 32'h0;
            mem_data_w <= 32'h0;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr[1:0];
                        r_wdata  <= req_wdata;
                        if (w_err) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'h0;
                        end else if (w_is_sw) begin
                            r_state    <= WRITE;
                            mem_dmem   <= 1'b0;
                            mem_addr   <= {2'b00, req_addr[31:2]};
                            mem_data_w <= req_wdata;
                        end else begin
                            r_state  <= READ;
                            mem_addr <= {2'b00, req_addr[31:2]};
                        end
                    end
                end
                READ: r_state <= CAPT;
                CAPT: begin
                    if (r_store) begin
                        r_state    <= WRITE;
                        mem_dmem   <= 1'b0;
                        mem_data_w <= w_merged;
                    end else begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= w_load;
                    end
                end
                WRITE: begin
                    r_state    <= RESP;
                    mem_dmem   <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= 32'h0;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state    <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    mem_dmem <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: sits between the execute/memory pipeline stage and the word-organised data memory (one-cycle registered read, combinational write whenever its select is low).
- Accepts one byte/half/word load or store request at a time and translates it into word-addressed memory accesses.
- Sub-word stores are done as read-modify-write.
- Load data is aligned and sign/zero-extended before the response is returned with a valid/ready handshake.

Parameters:
- MEM_WORDS, 21, number of 32-bit words in the data memory; word indices >= MEM_WORDS are out of range.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_store  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned in the low bits
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_data  output  32  extended load data (0 for stores and errors)
- resp_err  output  1  misaligned, out-of-range or illegal funct3
- mem_dmem  output  1  1=read, 0=write
- mem_addr  output  32  word index, equal to req_addr[31:2]
- mem_data_w  output  32  write word
- mem_data_r  input  32  read word, valid the cycle after a read address is presented

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - Outputs: mem_dmem=1, mem_addr=0, mem_data_w=0, resp_valid=0, resp_data=0, resp_err=0.
  - req_ready=0 while rst is low.
- Memory write rule: mem_dmem is 0 only in state WRITE, for exactly one cycle per store, and is 1 in every other state. The memory writes combinationally when the select is low, so no glitch to 0 is permitted. mem_addr and mem_data_w must be stable throughout WRITE.
- req_ready = (state==IDLE). On the accept edge (req_valid & req_ready), latch req_store, req_funct3, req_addr and req_wdata.
- Error check on acceptance:
  - Error conditions: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3[2]=1; addr[31:2] >= MEM_WORDS.
  - On error, go to RESP with resp_err=1 and resp_data=0. No memory access is made.
- FSM:
  - IDLE: on accept, go to RESP if error, to WRITE if SW, otherwise to READ (loads, SB, SH).
  - READ: mem_addr = word index, mem_dmem=1. Always goes to CAPT.
  - CAPT: sample mem_data_r.
    - Load: select byte addr[1:0] or half addr[1], sign-extend (B/H) or zero-extend (BU/HU), place in resp_data, go to RESP.
    - SB/SH: merge req_wdata[7:0] or [15:0] into the read word at the byte/half lane, leaving other lanes unchanged, and go to WRITE.
  - WRITE: mem_dmem=0, mem_addr=index, mem_data_w = req_wdata (SW) or the merged word. Always goes to RESP.
  - RESP: resp_valid=1. resp_data and resp_err are held stable until resp_ready=1; on that edge go to IDLE and clear resp_valid.
- Latency, counted from the accept edge to the first resp_valid cycle: error 1, SW 2, load 3, SB/SH 4.
- Throughput: a new request can be accepted no earlier than the cycle after the response handshake. There is no overlap.
- Back-to-back: a load immediately after a store to the same word returns the newly stored data.
- Reset mid-operation: all in-flight work is dropped and no response is produced. If reset hits during WRITE, mem_dmem goes to 1 immediately; whether that word was updated is undefined.

Test Plan:
- Reset: hold rst low 3 cycles -> mem_dmem=1, resp_valid=0, req_ready=0; after release req_ready=1.
- Word store/load:
  - SW addr 0x8 data 0xDEADBEEF -> cycle 1: mem_dmem=0, mem_addr=2, mem_data_w=0xDEADBEEF; cycle 2: resp_valid=1, resp_err=0.
  - Then LW 0x8 -> resp_data=0xDEADBEEF, 3 cycles after accept.
- Byte RMW:
  - SB 0x9 data 0x123456AA -> READ then WRITE with mem_data_w=0xDEADAAEF, mem_dmem low exactly one cycle.
  - Then LB 0x9 -> 0xFFFFFFAA; LBU 0x9 -> 0x000000AA.
- Halves: LH 0xA -> 0xFFFFDEAD; LHU 0xA -> 0x0000DEAD; SH 0x8 data 0x1234 then LW 0x8 -> 0xDEAD1234.
- Errors: LW 0x6, LH 0x3, SW 0x54 (word 21) and funct3=011 -> each gives resp_err=1 at cycle 1, resp_data=0, mem_dmem never 0.
- Backpressure and reset:
  - LW with resp_ready low 5 cycles -> resp_valid/resp_data held, req_ready=0, mem_dmem=1.
  - rst low during READ of an SB -> immediate IDLE, no write, no response.
